// File: rtl/cb_adder_pipe_pkg.sv
// Shared constants and configuration helpers for the pipelined carry-bypass adder.
package cb_adder_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_BLK   = 4;
  localparam int unsigned DEF_NBLK  = DEF_WIDTH / DEF_BLK;

  // One pipeline stage per carry-bypass block.
  function automatic int unsigned nblk_f(input int unsigned width, input int unsigned blk);
    return width / blk;
  endfunction

  function automatic bit cfg_ok_f(input int unsigned width, input int unsigned blk);
    return (blk != 0) && ((width % blk) == 0) && (width >= 4) && (width <= 64);
  endfunction

endpackage

// File: rtl/cb_block.sv
// Combinational BLK-bit ripple adder with block propagate and carry bypass mux.
module cb_block
  import cb_adder_pipe_pkg::*;
#(
  parameter int unsigned BLK = DEF_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s_c,
  output logic           co_c,
  output logic           p_c,
  output logic           ovf_c
);

  logic [BLK:0] c;

  always_comb begin
    c     = '0;
    s_c   = '0;
    c[0]  = ci;
    for (int i = 0; i < int'(BLK); i++) begin
      s_c[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
    p_c   = &(a ^ b);
    // A fully propagating block forwards its carry-in directly.
    co_c  = p_c ? ci : c[BLK];
    ovf_c = c[BLK-1] ^ co_c;
  end

endmodule

// File: rtl/cb_adder_pipe.sv
// Pipelined carry-bypass adder/subtractor: one BLK-bit block per stage with
// valid/ready flow control and bubble collapsing.
module cb_adder_pipe
  import cb_adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned BLK   = DEF_BLK
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  input  logic                        cin,
  input  logic                        sub,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            sum,
  output logic                        cout,
  output logic                        ovf,
  output logic [nblk_f(WIDTH,BLK)-1:0] skip_mask
);

  localparam int unsigned NBLK = nblk_f(WIDTH, BLK);

  if (!cfg_ok_f(WIDTH, BLK)) begin : g_cfg_err
    $error("cb_adder_pipe: WIDTH must be a multiple of BLK in 4..64");
  end

  logic [NBLK-1:0]  v_q, v_d, c_q, c_d, load_c;
  logic [WIDTH-1:0] a_q [NBLK];
  logic [WIDTH-1:0] a_d [NBLK];
  logic [WIDTH-1:0] b_q [NBLK];
  logic [WIDTH-1:0] b_d [NBLK];
  logic [WIDTH-1:0] sum_q [NBLK];
  logic [WIDTH-1:0] sum_d [NBLK];
  logic [NBLK-1:0]  skip_q [NBLK];
  logic [NBLK-1:0]  skip_d [NBLK];
  logic             ovf_q, ovf_d;

  logic [NBLK-1:0]  st_v, st_c;
  logic [WIDTH-1:0] st_a [NBLK];
  logic [WIDTH-1:0] st_b [NBLK];
  logic [WIDTH-1:0] st_sum [NBLK];
  logic [NBLK-1:0]  st_skip [NBLK];

  logic [BLK-1:0]   blk_s [NBLK];
  logic [NBLK-1:0]  blk_co, blk_p;
  logic             blk_ovf [NBLK];

  // Operands travel shifted so each stage always consumes the low BLK bits.
  for (genvar k = 0; k < int'(NBLK); k++) begin : g_stage
    if (k == 0) begin : g_in
      assign st_v[k]    = in_valid;
      assign st_a[k]    = a;
      assign st_b[k]    = sub ? ~b : b;
      assign st_c[k]    = sub | cin;
      assign st_sum[k]  = '0;
      assign st_skip[k] = '0;
    end else begin : g_chain
      assign st_v[k]    = v_q[k-1];
      assign st_a[k]    = a_q[k-1];
      assign st_b[k]    = b_q[k-1];
      assign st_c[k]    = c_q[k-1];
      assign st_sum[k]  = sum_q[k-1];
      assign st_skip[k] = skip_q[k-1];
    end

    cb_block #(.BLK(BLK)) u_blk (
      .a     (st_a[k][BLK-1:0]),
      .b     (st_b[k][BLK-1:0]),
      .ci    (st_c[k]),
      .s_c   (blk_s[k]),
      .co_c  (blk_co[k]),
      .p_c   (blk_p[k]),
      .ovf_c (blk_ovf[k])
    );
  end

  always_comb begin
    v_d    = v_q;
    c_d    = c_q;
    a_d    = a_q;
    b_d    = b_q;
    sum_d  = sum_q;
    skip_d = skip_q;
    ovf_d  = ovf_q;
    load_c = '0;
    for (int k = 0; k < int'(NBLK); k++) begin
      // Stage k advances if any stage from k upward is empty, or the output drains.
      load_c[k] = out_ready | ((~v_q >> k) != '0);
      if (load_c[k]) begin
        v_d[k] = st_v[k];
        if (st_v[k]) begin
          a_d[k]    = st_a[k] >> BLK;
          b_d[k]    = st_b[k] >> BLK;
          c_d[k]    = blk_co[k];
          sum_d[k]  = (st_sum[k] >> BLK) | (WIDTH'(blk_s[k]) << (WIDTH - BLK));
          skip_d[k] = (st_skip[k] >> 1) | (NBLK'(blk_p[k]) << (NBLK - 1));
        end
      end
    end
    if (load_c[NBLK-1] && st_v[NBLK-1]) begin
      ovf_d = blk_ovf[NBLK-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(NBLK); k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        sum_q[k]  <= '0;
        skip_q[k] <= '0;
      end
    end else begin
      v_q    <= v_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      a_q    <= a_d;
      b_q    <= b_d;
      sum_q  <= sum_d;
      skip_q <= skip_d;
    end
  end

  assign in_ready  = load_c[0];
  assign out_valid = v_q[NBLK-1];
  assign sum       = sum_q[NBLK-1];
  assign cout      = c_q[NBLK-1];
  assign ovf       = ovf_q;
  assign skip_mask = skip_q[NBLK-1];

endmodule
